// File: rtl/fifo_arb_pkg.sv
// Shared constants, FSM encoding and length helper for the DMAC FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_t;

  // A zero-length request still moves one word; oversize requests are clamped.
  function automatic logic [CNT_W-1:0] eff_len(input logic [31:0] field,
                                               input logic [31:0] max_burst);
    logic [CNT_W-1:0] w_len;
    if (field == 32'd0) begin
      w_len = 5'd1;
    end else if (field > max_burst) begin
      w_len = max_burst[CNT_W-1:0];
    end else begin
      w_len = field[CNT_W-1:0];
    end
    return w_len;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Channel-request and FIFO-write bundle between the requesting channels and the arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic [N_CH-1:0]        req;
  logic [N_CH*LEN_W-1:0]  burst_len;
  logic [N_CH-1:0]        ch_valid;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [CNT_W-1:0]       fifo_data_count;
  logic                   fifo_full;
  logic [N_CH-1:0]        gnt;
  logic [N_CH-1:0]        beat_ack;
  logic [N_CH-1:0]        done;
  logic                   fifo_wr_en;
  logic [DATA_W-1:0]      fifo_din;

  modport slave (
    input  req, burst_len, ch_valid, ch_data, fifo_data_count, fifo_full,
    output gnt, beat_ack, done, fifo_wr_en, fifo_din
  );

  modport master (
    output req, burst_len, ch_valid, ch_data, fifo_data_count, fifo_full,
    input  gnt, beat_ack, done, fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: first eligible channel at or after the pointer, wrapping.
module rr_picker #(
  parameter int N_CH  = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_CH-1:0]  i_elig,
  input  logic [PTR_W-1:0] i_rr_ptr,
  output logic [N_CH-1:0]  o_win,
  output logic             o_any
);

  logic [PTR_W-1:0] w_idx;
  logic             w_hit;

  // Walk channels in rotation order; the first hit latches o_any and blocks later ones.
  always_comb begin
    o_win = '0;
    o_any = 1'b0;
    w_idx = '0;
    w_hit = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      w_idx        = PTR_W'((int'(i_rr_ptr) + k) % N_CH);
      w_hit        = i_elig[w_idx] & ~o_any;
      o_win[w_idx] = o_win[w_idx] | w_hit;
      o_any        = o_any | w_hit;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Sole writer of the shared 16-entry DMAC FIFO: grants whole bursts round-robin,
// admitting a burst only when the FIFO has room for all of it.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int MAX_BURST = 8
) (
  input logic              clk,
  input logic              reset,
  fifo_wr_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N_CH);

  arb_state_t       r_state, w_state_nxt;
  logic [N_CH-1:0]  r_gnt, w_gnt_nxt;
  logic [N_CH-1:0]  r_done, w_done_nxt;
  logic [PTR_W-1:0] r_gidx, w_gidx_nxt;
  logic [PTR_W-1:0] r_rr_ptr, w_rr_nxt;
  logic [CNT_W-1:0] r_beats, w_beats_nxt;

  logic [CNT_W-1:0]  w_space;
  logic [CNT_W-1:0]  w_eff_len [N_CH];
  logic [N_CH-1:0]   w_elig;
  logic [N_CH-1:0]   w_win;
  logic              w_any;
  logic [PTR_W-1:0]  w_win_idx;
  logic              w_wr_en;
  logic [N_CH-1:0]   w_beat_ack;
  logic [DATA_W-1:0] w_din;

  // Count never exceeds the depth, so the free-space subtraction cannot wrap.
  always_comb begin
    w_space = DEPTH_CNT - bus.fifo_data_count;
    w_elig  = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_eff_len[i] = eff_len(32'(bus.burst_len[i*LEN_W +: LEN_W]), 32'(MAX_BURST));
      w_elig[i]    = bus.req[i] & (w_space >= w_eff_len[i]);
    end
  end

  rr_picker #(
    .N_CH  (N_CH),
    .PTR_W (PTR_W)
  ) u_picker (
    .i_elig   (w_elig),
    .i_rr_ptr (r_rr_ptr),
    .o_win    (w_win),
    .o_any    (w_any)
  );

  // One-hot winner to binary index.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_win_idx = w_win_idx | (w_win[i] ? PTR_W'(i) : {PTR_W{1'b0}});
    end
  end

  // Next-state and write-path decode; the write path only depends on registered grant state.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_gidx_nxt  = r_gidx;
    w_rr_nxt    = r_rr_ptr;
    w_beats_nxt = r_beats;
    w_done_nxt  = '0;
    w_wr_en     = 1'b0;
    w_beat_ack  = '0;
    w_din       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_BURST;
          w_gnt_nxt   = w_win;
          w_gidx_nxt  = w_win_idx;
          w_beats_nxt = w_eff_len[w_win_idx];
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
        end
      end
      ST_BURST: begin
        w_din = bus.ch_data[int'(r_gidx)*DATA_W +: DATA_W];
        if (!bus.req[r_gidx]) begin
          w_state_nxt        = ST_DONE;
          w_gnt_nxt          = '0;
          w_done_nxt[r_gidx] = 1'b1;
        end else if (bus.ch_valid[r_gidx] && !bus.fifo_full) begin
          w_wr_en            = 1'b1;
          w_beat_ack[r_gidx] = 1'b1;
          w_beats_nxt        = r_beats - 5'd1;
          if (r_beats == 5'd1) begin
            w_state_nxt        = ST_DONE;
            w_gnt_nxt          = '0;
            w_done_nxt[r_gidx] = 1'b1;
          end else begin
            w_state_nxt = ST_BURST;
          end
        end else begin
          w_state_nxt = ST_BURST;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        if (r_gidx == PTR_W'(N_CH - 1)) begin
          w_rr_nxt = '0;
        end else begin
          w_rr_nxt = r_gidx + PTR_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant, completion pulse, rotation pointer and beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt    <= '0;
      r_done   <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= '0;
      r_beats  <= '0;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_gidx   <= w_gidx_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_beats  <= w_beats_nxt;
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.done       = r_done;
  assign bus.fifo_wr_en = w_wr_en;
  assign bus.beat_ack   = w_beat_ack;
  assign bus.fifo_din   = w_din;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed plus randomized bench for fifo_wr_arbiter against a transaction-level grant/write model.
module tb_fifo_wr_arbiter;

  localparam int N_CH      = 4;
  localparam int DATA_W    = 32;
  localparam int LEN_W     = 4;
  localparam int MAX_BURST = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_CH(N_CH), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  fifo_wr_arbiter #(
    .N_CH(N_CH), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [N_CH-1:0] m_req;
  int              m_len [N_CH];
  int              m_cnt;
  int              rr_model;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int l);
    return (l == 0) ? 1 : ((l > MAX_BURST) ? MAX_BURST : l);
  endfunction

  // First requesting channel from rr_model whose clamped length fits the free space.
  function automatic int predict();
    for (int k = 0; k < N_CH; k++) begin
      int c;
      c = (rr_model + k) % N_CH;
      if (m_req[c] && (16 - m_cnt) >= eff(m_len[c])) return c;
    end
    return -1;
  endfunction

  task automatic push_inputs();
    bus.req = m_req;
    for (int i = 0; i < N_CH; i++) bus.burst_len[i*LEN_W +: LEN_W] = LEN_W'(m_len[i]);
    bus.fifo_data_count = 5'(m_cnt);
  endtask

  // mode 0: always ready; 1: random stalls; 2: valid low 2 cycles after beat 1, full 1 cycle after beat 2
  task automatic drive_cycle(input int mode, input int writes, input int since_wr);
    for (int i = 0; i < N_CH; i++) bus.ch_data[i*DATA_W +: DATA_W] = $urandom;
    case (mode)
      0: begin
        bus.ch_valid  = '1;
        bus.fifo_full = 1'b0;
      end
      1: begin
        for (int i = 0; i < N_CH; i++) bus.ch_valid[i] = ($urandom_range(0, 3) != 0);
        bus.fifo_full = ($urandom_range(0, 7) == 0);
      end
      default: begin
        bus.ch_valid  = (writes == 1 && since_wr < 2) ? '0 : '1;
        bus.fifo_full = (writes == 2 && since_wr < 1);
      end
    endcase
  endtask

  task automatic run_burst(input string tag, input int exp_ch, input int exp_writes,
                           input int abort_at, input int mode);
    int writes = 0, since_wr = 0, lat = -1, last_wr = -1, drop_cyc = -1, done_cyc = -1;
    int bad_data = 0, bad_ack = 0, illegal = 0;
    bit granted = 1'b0, finished = 1'b0;
    logic presented_ok;
    logic [N_CH-1:0] gnt_seen = '0, done_seen = '0, gnt_at_done = '0;
    logic [N_CH-1:0] exp_oh;
    exp_oh = N_CH'(1 << exp_ch);
    for (int c = 0; c < 300 && !finished; c++) begin
      drive_cycle(mode, writes, since_wr);
      if (granted && abort_at >= 0 && writes == abort_at && bus.req[exp_ch]) begin
        bus.req[exp_ch] = 1'b0;
        m_req[exp_ch]   = 1'b0;
        drop_cyc        = c;
      end
      presented_ok = bus.ch_valid[exp_ch] && !bus.fifo_full && bus.req[exp_ch];
      @(negedge clk);
      if (!granted && bus.gnt != '0) begin
        granted  = 1'b1;
        gnt_seen = bus.gnt;
        lat      = c;
      end
      if (bus.fifo_wr_en) begin
        writes++;
        since_wr = 0;
        last_wr  = c;
        if (!granted || !presented_ok) illegal++;
        if (bus.fifo_din !== bus.ch_data[exp_ch*DATA_W +: DATA_W]) bad_data++;
        if (bus.beat_ack !== exp_oh) bad_ack++;
      end else begin
        since_wr++;
        if (bus.beat_ack !== '0) bad_ack++;
      end
      if (bus.done != '0) begin
        finished    = 1'b1;
        done_seen   = bus.done;
        done_cyc    = c;
        gnt_at_done = bus.gnt;
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_timeout"}, 64'(finished), 64'd1);
    check({tag, "_gnt"}, 64'(gnt_seen), 64'(exp_oh));
    check({tag, "_gnt_lat"}, 64'(lat), 64'd1);
    check({tag, "_writes"}, 64'(writes), 64'(exp_writes));
    check({tag, "_data"}, 64'(bad_data), 64'd0);
    check({tag, "_beat_ack"}, 64'(bad_ack), 64'd0);
    check({tag, "_stall_wr"}, 64'(illegal), 64'd0);
    check({tag, "_done"}, 64'(done_seen), 64'(exp_oh));
    check({tag, "_gnt_clr"}, 64'(gnt_at_done), 64'd0);
    check({tag, "_done_time"}, 64'(done_cyc),
          64'((drop_cyc >= 0) ? drop_cyc + 1 : last_wr + 1));
    rr_model = (exp_ch + 1) % N_CH;
  endtask

  task automatic expect_idle(input string tag, input int n);
    int bad = 0;
    for (int c = 0; c < n; c++) begin
      drive_cycle(0, 0, 0);
      @(negedge clk);
      if (bus.gnt != '0 || bus.fifo_wr_en) bad++;
      @(posedge clk);
      #1;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pred, wcount, abort_at, e;
    reset = 1'b1;
    m_req = '0;
    m_cnt = 0;
    for (int i = 0; i < N_CH; i++) m_len[i] = 0;
    push_inputs();
    bus.ch_valid  = '0;
    bus.ch_data   = '0;
    bus.fifo_full = 1'b0;
    rr_model      = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    check("rst_beat_ack", 64'(bus.beat_ack), 64'd0);
    reset = 1'b0;

    // Single burst: ch1, length 4, empty FIFO
    m_req = 4'b0010; m_len[1] = 4; m_cnt = 0; push_inputs();
    run_burst("single", predict(), 4, -1, 0);
    m_req = '0; push_inputs();

    // Asynchronous reset in the middle of a ch2 burst
    m_req = 4'b0100; m_len[2] = 8; push_inputs();
    wcount = 0;
    for (int c = 0; c < 20 && wcount < 2; c++) begin
      drive_cycle(0, 0, 0);
      @(negedge clk);
      if (bus.fifo_wr_en) wcount++;
      @(posedge clk);
      #1;
    end
    drive_cycle(0, 0, 0);
    check("midrst_pre_gnt", 64'(bus.gnt), 64'(4'b0100));
    check("midrst_pre_wr_en", 64'(bus.fifo_wr_en), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_gnt", 64'(bus.gnt), 64'd0);
    check("midrst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_beat_ack", 64'(bus.beat_ack), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rr_model = 0;

    // Fairness from a freshly reset pointer: expect 0,1,2,3,0
    m_req = 4'b1111; m_cnt = 0;
    for (int i = 0; i < N_CH; i++) m_len[i] = 2;
    push_inputs();
    reset = 1'b0;
    for (int b = 0; b < 5; b++) begin
      pred = predict();
      check("fair_order", 64'(pred), 64'(b % N_CH));
      run_burst("fair", pred, 2, -1, 0);
    end
    m_req = '0; push_inputs();

    // Stall: ch3, length 3, valid gap then full
    m_req = 4'b1000; m_len[3] = 3; push_inputs();
    run_burst("stall", predict(), 3, -1, 2);
    m_req = '0; push_inputs();

    // Admission: 2 free words; ch0 wants 4, ch1 wants 2
    m_req = 4'b0011; m_len[0] = 4; m_len[1] = 2; m_cnt = 14; push_inputs();
    pred = predict();
    check("admit_pick", 64'(pred), 64'd1);
    run_burst("admit_ch1", pred, 2, -1, 0);
    m_req[1] = 1'b0; push_inputs();
    expect_idle("admit_hold", 4);
    m_cnt = 12; push_inputs();
    run_burst("admit_ch0", predict(), 4, -1, 0);
    m_req = '0; m_cnt = 0; push_inputs();

    // Clamp: zero length means one word, oversize clamps to MAX_BURST
    m_req = 4'b0100; m_len[2] = 0; push_inputs();
    run_burst("clamp0", predict(), 1, -1, 1);
    m_req = 4'b1000; m_len[3] = 15; m_cnt = 8; push_inputs();
    run_burst("clamp15", predict(), 8, -1, 1);
    m_req = '0; m_cnt = 0; push_inputs();

    // Abort after 2 of 5 beats
    m_req = 4'b0010; m_len[1] = 5; push_inputs();
    run_burst("abort", predict(), 2, 2, 0);
    m_req = '0; push_inputs();

    // Randomized requests, lengths, occupancy, stalls and aborts
    for (int t = 0; t < 40; t++) begin
      m_req = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      for (int i = 0; i < N_CH; i++) m_len[i] = $urandom_range(0, 15);
      m_cnt = $urandom_range(0, 16);
      push_inputs();
      pred = predict();
      if (pred < 0) begin
        expect_idle("rnd_noelig", 3);
        m_cnt = 0;
        push_inputs();
        pred = predict();
      end
      e = eff(m_len[pred]);
      abort_at = (e >= 2 && $urandom_range(0, 4) == 0) ? $urandom_range(1, e - 1) : -1;
      run_burst("rnd", pred, (abort_at >= 0) ? abort_at : e, abort_at, $urandom_range(0, 1));
      m_req = '0;
      push_inputs();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
